// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I data memory responder with wait states; MISALIGN_TRAP_EN traps misaligned H/W accesses
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        go_resp;
    logic        cur_we;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] off;
    logic        in_range;
    logic [IDX_W-1:0] idx;
    logic [1:0]  lane;
    logic        f3_ok;
    logic        misalign;
    logic        err;
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic        mem_wr;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = (state == S_IDLE) && req_valid;

    // With zero wait states the access resolves on the accept edge, so decode
    // straight from the request bus instead of the (not yet loaded) latches.
    always_comb begin
        if (state == S_IDLE) begin
            cur_we    = req_we;
            cur_f3    = req_funct3;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_we    = lat_we;
            cur_f3    = lat_f3;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        go_resp    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_RESP;
                        go_resp    = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_RESP;
                    go_resp    = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
        end
    end

    // Decode: offset compare is done in 33 bits so large depths cannot overflow.
    always_comb begin
        off      = cur_addr - BASE_ADDR;
        in_range = ({1'b0, off} < LIMIT);
        idx      = off[IDX_W+1:2];
        lane     = off[1:0];
        if (cur_we)
            f3_ok = (cur_f3 == 3'b000) || (cur_f3 == 3'b001) || (cur_f3 == 3'b010);
        else
            f3_ok = (cur_f3 == 3'b000) || (cur_f3 == 3'b001) || (cur_f3 == 3'b010) ||
                    (cur_f3 == 3'b100) || (cur_f3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
        misalign = ((cur_f3[1:0] == 2'b01) && lane[0]) ||
                   ((cur_f3[1:0] == 2'b10) && (lane != 2'b00));
`else
        misalign = 1'b0;
`endif
        err = !in_range || !f3_ok || misalign;
    end

    always_comb begin
        rd_word  = mem[idx];
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = rd_word[{lane[1], 4'b0000} +: 16];
        case (cur_f3)
            3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_data = {24'd0, byte_sel};
            3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ld_data = {16'd0, half_sel};
            3'b010:  ld_data = rd_word;
            default: ld_data = 32'd0;
        endcase
    end

    always_comb begin
        st_be   = 4'b0000;
        st_data = cur_wdata;
        case (cur_f3)
            3'b000: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{cur_wdata[7:0]}};
            end
            3'b001: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{cur_wdata[15:0]}};
            end
            3'b010: begin
                st_be   = 4'b1111;
                st_data = cur_wdata;
            end
            default: begin
                st_be   = 4'b0000;
            end
        endcase
    end

    // Commit on the edge entering RESP; reset low suppresses any pending write.
    assign mem_wr = rst_n && go_resp && cur_we && !err;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b])
                    mem[idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (go_resp) begin
            rsp_rdata <= (cur_we || err) ? 32'd0 : ld_data;
            rsp_err   <= err;
        end else if (state == S_RESP) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (default WAIT_CYCLES=1)
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks;
    int failures;

    dmem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, return the response and the number of cycles from
    // the accept edge until rsp_valid is seen (99 if it never arrives).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int lat);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = 99;
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sw_lw();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", er); end
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL sw_rdata got=%h exp=0", rd); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_one_shot got=%b exp=0", rsp_valid); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_subword_loads();
        logic [31:0] rd; logic er; int lat;
        logic [2:0]  f3 [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad [4]  = '{32'h23, 32'h23, 32'h20, 32'h22};
        logic [31:0] ex [4]  = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080F0};
        do_req(1'b1, 3'b010, 32'h20, 32'h80F07F01, rd, er, lat);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3[i], ad[i], 32'h0, rd, er, lat);
            checks++;
            if (rd !== ex[i] || er !== 1'b0 || lat !== 2) begin
                failures++;
                $display("FAIL subload_%0d got=%h err=%b lat=%0d exp=%h err=0 lat=2", i, rd, er, lat, ex[i]);
            end
        end
    endtask

    task automatic test_subword_stores();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 32'h30, 32'h11223344, rd, er, lat);
        do_req(1'b1, 3'b000, 32'h31, 32'h000000AB, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL sb_err got=%b exp=0", er); end
        do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h1122AB44) begin failures++; $display("FAIL sb_word got=%h exp=1122ab44", rd); end
        do_req(1'b1, 3'b001, 32'h32, 32'h0000CDEF, rd, er, lat);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hCDEFAB44) begin failures++; $display("FAIL sh_word got=%h exp=cdefab44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 32'h0, 32'h0BADF00D, rd, er, lat);
        do_req(1'b1, 3'b010, 32'h1000, 32'h11111111, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin failures++; $display("FAIL oor_store got=%h err=%b lat=%0d exp=0 err=1 lat=2", rd, er, lat); end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL oor_no_alias got=%h exp=0badf00d", rd); end
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL oor_load got=%h err=%b exp=0 err=1", rd, er); end
        do_req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL oor_top got=%h err=%b exp=0 err=1", rd, er); end
        do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL bad_f3_load got=%h err=%b exp=0 err=1", rd, er); end
        do_req(1'b1, 3'b100, 32'h10, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL bad_f3_store got=%b exp=1", er); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL bad_f3_nowrite got=%h err=%b exp=deadbeef err=0", rd, er); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 32'h40, 32'hA5A51234, rd, er, lat);
        do_req(1'b0, 3'b010, 32'h41, 32'h0, rd, er, lat);
`ifdef MISALIGN_TRAP_EN
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin failures++; $display("FAIL misalign_lw got=%h err=%b lat=%0d exp=0 err=1 lat=2", rd, er, lat); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'hA5A51234) begin failures++; $display("FAIL misalign_lw got=%h err=%b exp=a5a51234 err=0", rd, er); end
`endif
        do_req(1'b0, 3'b001, 32'h43, 32'h0, rd, er, lat);
`ifdef MISALIGN_TRAP_EN
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL misalign_lh got=%h err=%b exp=0 err=1", rd, er); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'hFFFFA5A5) begin failures++; $display("FAIL misalign_lh got=%h err=%b exp=ffffa5a5 err=0", rd, er); end
`endif
    endtask

    task automatic test_back_to_back();
        int n_rsp; int n_rdy;
        n_rsp = 0; n_rdy = 0;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) n_rsp++;
            if (req_ready === 1'b1) n_rdy++;
            if (i == 0) begin
                checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL ready_in_wait got=%b exp=0", req_ready); end
            end
        end
        req_valid = 1'b0;
        checks++; if (n_rsp !== 3) begin failures++; $display("FAIL b2b_responses got=%0d exp=3", n_rsp); end
        checks++; if (n_rdy !== 3) begin failures++; $display("FAIL b2b_ready_cycles got=%0d exp=3", n_rdy); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; int n_rsp;
        do_req(1'b1, 3'b010, 32'h50, 32'h12345678, rd, er, lat);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_async got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        n_rsp = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) n_rsp++;
        end
        checks++; if (n_rsp !== 0) begin failures++; $display("FAIL abort_no_rsp got=%0d exp=0", n_rsp); end
        do_req(1'b0, 3'b010, 32'h50, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL abort_discard got=%h exp=12345678", rd); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sw_lw();
        test_subword_loads();
        test_subword_stores();
        test_errors();
        test_misalign();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
